ttt_game_ctrl: RTL and testbench



---
 rtl/ttt_game_ctrl_if.sv | 27 ++
 rtl/ttt_game_ctrl.sv | 172 +++++++++++++++++
 tb/tb_ttt_game_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ttt_game_ctrl_if.sv
// Rotary-encoder inputs and board/status outputs of the tic-tac-toe controller.
// The master side is whatever drives the encoder; the slave side is the controller.
interface ttt_game_ctrl_if;
  logic       rot_a;
  logic       rot_b;
  logic       rot_press;
  logic [7:0] square_num;
  logic [8:0] board_p1;
  logic [8:0] board_p2;
  logic       player_turn;
  logic       player_1_win;
  logic       player_2_win;
  logic       game_draw;
  logic       move_reject;

  modport master (
    output rot_a, rot_b, rot_press,
    input  square_num, board_p1, board_p2, player_turn,
    input  player_1_win, player_2_win, game_draw, move_reject
  );

  modport slave (
    input  rot_a, rot_b, rot_press,
    output square_num, board_p1, board_p2, player_turn,
    output player_1_win, player_2_win, game_draw, move_reject
  );
endinterface

// File: rtl/ttt_game_ctrl.sv
// Two-player tic-tac-toe controller: a rotary encoder moves the cursor,
// a push marks the square, and a one-cycle check state resolves win/draw.
module ttt_game_ctrl #(
  parameter int unsigned FIRST_SQUARE = 1
) (
  input logic             clk,
  input logic             clr,
  ttt_game_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  localparam logic [3:0] FIRST_SQ = 4'(FIRST_SQUARE);

  logic [1:0] state_q, state_d;
  logic [3:0] sq_q, sq_d;
  logic [8:0] p1_q, p1_d;
  logic [8:0] p2_q, p2_d;
  logic       turn_q, turn_d;
  logic       win1_q, win1_d;
  logic       win2_q, win2_d;
  logic       draw_q, draw_d;
  logic       rej_q, rej_d;
  logic       rot_a_q, rot_a_d;
  logic       press_q, press_d;

  logic       rot_ev;
  logic       press_ev;
  logic [3:0] sq_inc;
  logic [3:0] sq_dec;
  logic [8:0] sq_onehot;
  logic [8:0] occupied;
  logic [8:0] mover_board;

  function automatic logic has_line(input logic [8:0] b);
    return ((b & 9'h007) == 9'h007) ||  // 1 2 3
           ((b & 9'h038) == 9'h038) ||  // 4 5 6
           ((b & 9'h1C0) == 9'h1C0) ||  // 7 8 9
           ((b & 9'h049) == 9'h049) ||  // 1 4 7
           ((b & 9'h092) == 9'h092) ||  // 2 5 8
           ((b & 9'h124) == 9'h124) ||  // 3 6 9
           ((b & 9'h111) == 9'h111) ||  // 1 5 9
           ((b & 9'h054) == 9'h054);    // 3 5 7
  endfunction

  assign rot_ev      = bus.rot_a & ~rot_a_q;
  assign press_ev    = bus.rot_press & ~press_q;
  assign sq_inc      = (sq_q >= 4'd9) ? 4'd1 : sq_q + 4'd1;
  assign sq_dec      = (sq_q <= 4'd1) ? 4'd9 : sq_q - 4'd1;
  assign sq_onehot   = 9'd1 << (sq_q - 4'd1);
  assign occupied    = p1_q | p2_q;
  assign mover_board = turn_q ? p2_q : p1_q;

  always_comb begin
    // NOTE: every _d gets a default before the case so no path can infer a latch.
    state_d = state_q;
    sq_d    = sq_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    turn_d  = turn_q;
    win1_d  = win1_q;
    win2_d  = win2_q;
    draw_d  = draw_q;
    rej_d   = 1'b0;
    rot_a_d = bus.rot_a;
    press_d = bus.rot_press;

    case (state_q)
      ST_IDLE: begin
        if (press_ev) begin
          sq_d    = FIRST_SQ;
          turn_d  = 1'b0;
          state_d = ST_PLAY;
        end
      end

      ST_PLAY: begin
        // The press acts on the cursor as it was before any same-cycle step.
        if (press_ev) begin
          if ((occupied & sq_onehot) != 9'd0) begin
            rej_d = 1'b1;
          end else begin
            if (turn_q) p2_d = p2_q | sq_onehot;
            else        p1_d = p1_q | sq_onehot;
            state_d = ST_CHECK;
          end
        end
        if (rot_ev) begin
          sq_d = bus.rot_b ? sq_dec : sq_inc;
        end
      end

      ST_CHECK: begin
        // Events landing here are dropped; the edge registers still track inputs.
        if (has_line(mover_board)) begin
          if (turn_q) win2_d = 1'b1;
          else        win1_d = 1'b1;
          state_d = ST_OVER;
        end else if (&occupied) begin
          draw_d  = 1'b1;
          state_d = ST_OVER;
        end else begin
          turn_d  = ~turn_q;
          state_d = ST_PLAY;
        end
      end

      ST_OVER: begin
        if (press_ev) begin
          sq_d    = 4'd0;
          p1_d    = 9'd0;
          p2_d    = 9'd0;
          turn_d  = 1'b0;
          win1_d  = 1'b0;
          win2_d  = 1'b0;
          draw_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      sq_q    <= 4'd0;
      p1_q    <= 9'd0;
      p2_q    <= 9'd0;
      turn_q  <= 1'b0;
      win1_q  <= 1'b0;
      win2_q  <= 1'b0;
      draw_q  <= 1'b0;
      rej_q   <= 1'b0;
      rot_a_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge _d values together.
      state_q <= state_d;
      sq_q    <= sq_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      turn_q  <= turn_d;
      win1_q  <= win1_d;
      win2_q  <= win2_d;
      draw_q  <= draw_d;
      rej_q   <= rej_d;
      rot_a_q <= rot_a_d;
      press_q <= press_d;
    end
  end

  assign bus.square_num   = {4'b0000, sq_q};
  assign bus.board_p1     = p1_q;
  assign bus.board_p2     = p2_q;
  assign bus.player_turn  = turn_q;
  assign bus.player_1_win = win1_q;
  assign bus.player_2_win = win2_q;
  assign bus.game_draw    = draw_q;
  assign bus.move_reject  = rej_q;

  // Outcome flags are mutually exclusive and the cursor stays within 0..9.
  a_flags_exclusive: assert property (@(posedge clk) disable iff (clr)
    !(win1_q && win2_q) && !((win1_q || win2_q) && draw_q));
  a_square_range: assert property (@(posedge clk) disable iff (clr)
    sq_q <= 4'd9);

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl: cursor wrap, win, reject, draw,
// held press, same-cycle rotate+press, and clear during the check state.
module tb_ttt_game_ctrl;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cur     = 0;

  ttt_game_ctrl_if bus ();

  ttt_game_ctrl #(.FIRST_SQUARE(1)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_sq"},   32'(bus.square_num), 32'd0);
    check({tag, "_p1"},   32'(bus.board_p1), 32'd0);
    check({tag, "_p2"},   32'(bus.board_p2), 32'd0);
    check({tag, "_turn"}, 32'(bus.player_turn), 32'd0);
    check({tag, "_flags"}, 32'({bus.player_1_win, bus.player_2_win, bus.game_draw, bus.move_reject}), 32'd0);
  endtask

  // One detent: rot_a high for a cycle, then low so the next detent is a fresh edge.
  task automatic rotate(input bit cw);
    bus.rot_b = !cw;
    bus.rot_a = 1'b1;
    @(negedge clk);
    bus.rot_a = 1'b0;
    bus.rot_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic press();
    bus.rot_press = 1'b1;
    @(negedge clk);
    bus.rot_press = 1'b0;
    @(negedge clk);
  endtask

  task automatic goto_sq(input int s);
    int n;
    n = (s - cur + 9) % 9;
    for (int i = 0; i < n; i++) rotate(1'b1);
    cur = s;
    check($sformatf("goto_%0d", s), 32'(bus.square_num), 32'(s));
  endtask

  task automatic move(input int s);
    goto_sq(s);
    press();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.rot_a     = 1'b0;
    bus.rot_b     = 1'b0;
    bus.rot_press = 1'b0;

    // Asynchronous reset, observed before any clock edge.
    #2 clr = 1'b1;
    #1 check_cleared("reset");
    @(negedge clk);
    clr = 1'b0;

    // Cursor: IDLE ignores rotation, press enters PLAY at square 1, wraps both ways.
    rotate(1'b1);
    check("idle_rot", 32'(bus.square_num), 32'd0);
    press();
    check("start_sq", 32'(bus.square_num), 32'd1);
    check("start_turn", 32'(bus.player_turn), 32'd0);
    cur = 1;
    for (int i = 2; i <= 10; i++) begin
      rotate(1'b1);
      check($sformatf("cw_%0d", i), 32'(bus.square_num), (i == 10) ? 32'd1 : 32'(i));
    end
    rotate(1'b0);
    check("ccw_wrap", 32'(bus.square_num), 32'd9);
    cur = 9;

    // Player 1 wins on the top row.
    move(1);
    check("turn_after_1", 32'(bus.player_turn), 32'd1);
    move(4);
    check("turn_after_2", 32'(bus.player_turn), 32'd0);
    move(2);
    move(5);
    goto_sq(3);
    bus.rot_press = 1'b1;
    @(negedge clk);
    check("win_early", 32'(bus.player_1_win), 32'd0);
    check("win_p1_marked", 32'(bus.board_p1), 32'h007);
    bus.rot_press = 1'b0;
    @(negedge clk);
    check("win_p1", 32'(bus.player_1_win), 32'd1);
    check("win_board_p1", 32'(bus.board_p1), 32'h007);
    check("win_board_p2", 32'(bus.board_p2), 32'h018);
    check("win_p2_flag", 32'(bus.player_2_win), 32'd0);
    check("win_draw_flag", 32'(bus.game_draw), 32'd0);
    rotate(1'b1);
    check("over_rot_cw", 32'(bus.square_num), 32'd3);
    rotate(1'b0);
    check("over_rot_ccw", 32'(bus.square_num), 32'd3);
    check("over_hold_win", 32'(bus.player_1_win), 32'd1);
    press();
    check_cleared("over_clear");

    // Reject a second press on square 5.
    press();
    cur = 1;
    move(5);
    check("rej_turn_before", 32'(bus.player_turn), 32'd1);
    goto_sq(5);
    bus.rot_press = 1'b1;
    @(negedge clk);
    check("rej_pulse", 32'(bus.move_reject), 32'd1);
    check("rej_p1", 32'(bus.board_p1), 32'h010);
    check("rej_p2", 32'(bus.board_p2), 32'h000);
    bus.rot_press = 1'b0;
    @(negedge clk);
    check("rej_one_cycle", 32'(bus.move_reject), 32'd0);
    check("rej_turn_after", 32'(bus.player_turn), 32'd1);
    check("rej_p1_after", 32'(bus.board_p1), 32'h010);

    // Clear mid-game discards it; next press starts fresh.
    clr = 1'b1;
    #1 check_cleared("mid_clr");
    @(negedge clk);
    clr = 1'b0;
    press();
    check("restart_sq", 32'(bus.square_num), 32'd1);
    check("restart_p1", 32'(bus.board_p1), 32'd0);
    cur = 1;

    // Draw game.
    move(1); move(2); move(3); move(5); move(4); move(6); move(8); move(7);
    check("draw_pending", 32'({bus.player_1_win, bus.player_2_win, bus.game_draw}), 32'd0);
    check("draw_turn8", 32'(bus.player_turn), 32'd0);
    move(9);
    check("draw_flag", 32'(bus.game_draw), 32'd1);
    check("draw_wins", 32'({bus.player_1_win, bus.player_2_win}), 32'd0);
    check("draw_p1", 32'(bus.board_p1), 32'h18D);
    check("draw_p2", 32'(bus.board_p2), 32'h072);
    check("draw_full", 32'(bus.board_p1 | bus.board_p2), 32'h1FF);
    press();
    check_cleared("draw_clear");

    // Long press gives exactly one move; rotate+press together marks the old square.
    press();
    cur = 1;
    bus.rot_press = 1'b1;
    repeat (20) @(negedge clk);
    bus.rot_press = 1'b0;
    @(negedge clk);
    check("hold_p1", 32'(bus.board_p1), 32'h001);
    check("hold_p2", 32'(bus.board_p2), 32'h000);
    check("hold_turn", 32'(bus.player_turn), 32'd1);
    goto_sq(3);
    bus.rot_b     = 1'b0;
    bus.rot_a     = 1'b1;
    bus.rot_press = 1'b1;
    @(negedge clk);
    bus.rot_a     = 1'b0;
    bus.rot_press = 1'b0;
    @(negedge clk);
    check("same_p2", 32'(bus.board_p2), 32'h004);
    check("same_sq", 32'(bus.square_num), 32'd4);
    check("same_p1", 32'(bus.board_p1), 32'h001);
    check("same_turn", 32'(bus.player_turn), 32'd0);
    cur = 4;

    // Clear while the controller sits in CHECK.
    goto_sq(5);
    bus.rot_press = 1'b1;
    @(negedge clk);
    check("chk_marked", 32'(bus.board_p1), 32'h011);
    bus.rot_press = 1'b0;
    clr = 1'b1;
    #1 check_cleared("chk_clr");
    @(negedge clk);
    clr = 1'b0;
    rotate(1'b1);
    check("chk_idle_rot", 32'(bus.square_num), 32'd0);
    press();
    check("chk_restart_sq", 32'(bus.square_num), 32'd1);
    check("chk_restart_turn", 32'(bus.player_turn), 32'd0);
    check("chk_restart_boards", 32'({bus.board_p1, bus.board_p2}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
